// File: rtl/tug_match.sv
// tug_match: best-of-N tug-of-war game engine.
//
// One position register replaces the chain of per-LED light cells. A light
// walks left on left presses and right on right presses; pushing it off an
// end wins the round. After a round win the field freezes for HOLD_CYCLES,
// then either re-centres for the next round or locks up once a player has
// WIN_ROUNDS round wins.
//
// Optional build macro TUG_EDGE_DETECT_EN:
//   defined   - l_press / r_press may be raw levels; only a 0->1 transition
//               counts as a press (one previous-value flop per input).
//   undefined - inputs are already one-cycle pulses; every high cycle is a
//               press and no edge flops exist.
//
// Parameter constraints: FIELD_LEDS odd and >= 3, WIN_ROUNDS >= 1,
// HOLD_CYCLES >= 1.

module tug_match #(
   parameter int FIELD_LEDS  = 9,
   parameter int WIN_ROUNDS  = 3,
   parameter int HOLD_CYCLES = 50000000,
   localparam int POS_W      = $clog2(FIELD_LEDS),
   localparam int SCORE_W    = $clog2(WIN_ROUNDS + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  l_press,
   input  logic                  r_press,
   output logic [FIELD_LEDS-1:0] field,
   output logic [SCORE_W-1:0]    score_l,
   output logic [SCORE_W-1:0]    score_r,
   output logic                  round_done,
   output logic                  round_winner,
   output logic                  match_over,
   output logic                  match_winner
);

   // Hold counter needs at least one bit even when HOLD_CYCLES == 1.
   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [POS_W-1:0]   POS_MAX   = POS_W'(FIELD_LEDS - 1);
   localparam logic [POS_W-1:0]   POS_MIN   = '0;
   localparam logic [POS_W-1:0]   CENTRE    = POS_W'((FIELD_LEDS - 1) / 2);
   localparam logic [POS_W-1:0]   POS_ONE   = POS_W'(1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(WIN_ROUNDS);
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      PLAY = 2'd0,
      HOLD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [SCORE_W-1:0]  score_l_d, score_r_d;
   logic                round_done_d;
   logic                round_winner_d;
   logic                match_over_d;
   logic                match_winner_d;
   logic                l_hit, r_hit;

   // Saturating score increment: a score never passes WIN_ROUNDS.
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
   endfunction

   // One-hot LED image of a position; bit 0 is the right end.
   function automatic logic [FIELD_LEDS-1:0] onehot(input logic [POS_W-1:0] p);
      logic [FIELD_LEDS-1:0] f;
      f = '0;
      for (int i = 0; i < FIELD_LEDS; i++) begin
         f[i] = (p == POS_W'(i));
      end
      return f;
   endfunction

`ifdef TUG_EDGE_DETECT_EN
   logic l_prev, r_prev;

   // Remember last input levels so a held button yields a single press.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         l_prev <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         l_prev <= l_press;
         r_prev <= r_press;
      end
   end

   assign l_hit = l_press & ~l_prev;
   assign r_hit = r_press & ~r_prev;
`else
   assign l_hit = l_press;
   assign r_hit = r_press;
`endif

   // Match state register plus all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= PLAY;
         pos_q        <= CENTRE;
         cnt_q        <= '0;
         field        <= onehot(CENTRE);
         score_l      <= '0;
         score_r      <= '0;
         round_done   <= 1'b0;
         round_winner <= 1'b0;
         match_over   <= 1'b0;
         match_winner <= 1'b0;
      end else begin
         state_q      <= state_d;
         pos_q        <= pos_d;
         cnt_q        <= cnt_d;
         field        <= onehot(pos_d);
         score_l      <= score_l_d;
         score_r      <= score_r_d;
         round_done   <= round_done_d;
         round_winner <= round_winner_d;
         match_over   <= match_over_d;
         match_winner <= match_winner_d;
      end
   end

   // Next-state logic: light movement, round wins, freeze and match end.
   always_comb begin
      state_d        = state_q;
      pos_d          = pos_q;
      cnt_d          = cnt_q;
      score_l_d      = score_l;
      score_r_d      = score_r;
      round_done_d   = 1'b0;
      round_winner_d = round_winner;
      match_over_d   = match_over;
      match_winner_d = match_winner;

      case (state_q)
         PLAY: begin
            // Simultaneous presses cancel each other out.
            if (l_hit && !r_hit) begin
               if (pos_q == POS_MAX) begin
                  score_l_d      = sat_inc(score_l);
                  round_winner_d = 1'b1;
                  round_done_d   = 1'b1;
                  cnt_d          = '0;
                  state_d        = HOLD;
               end else begin
                  pos_d = pos_q + POS_ONE;
               end
            end else if (r_hit && !l_hit) begin
               if (pos_q == POS_MIN) begin
                  score_r_d      = sat_inc(score_r);
                  round_winner_d = 1'b0;
                  round_done_d   = 1'b1;
                  cnt_d          = '0;
                  state_d        = HOLD;
               end else begin
                  pos_d = pos_q - POS_ONE;
               end
            end
         end

         HOLD: begin
            // Presses are ignored for the whole freeze, including the
            // cycle in which the field re-centres.
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               // The winner's score was already bumped on entry to HOLD.
               if ((score_l == SCORE_MAX) || (score_r == SCORE_MAX)) begin
                  state_d        = DONE;
                  match_over_d   = 1'b1;
                  match_winner_d = round_winner;
               end else begin
                  pos_d   = CENTRE;
                  state_d = PLAY;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         DONE: begin
            // Absorbing until reset.
         end

         default: begin
            state_d = PLAY;
            pos_d   = CENTRE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: doc/tug_match.md
Name: tug_match

Overview:
- Parametrised tug-of-war game engine for a best-of-N match. It replaces the fixed chain of per-LED light cells and the single-round victory cell with one position counter, per-player score counters and a match state machine.
- Sits after the metastability and keypress stages. It consumes one-cycle press pulses and drives the LED field plus score and winner status, which feed HEX decoders.

Parameters:
- FIELD_LEDS, 9, number of field LEDs. Must be odd and ≥3. Centre index is (FIELD_LEDS-1)/2.
- WIN_ROUNDS, 3, round wins needed to take the match (≥1).
- HOLD_CYCLES, 50000000, cycles the field freezes after a round win before re-centring (≥1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- l_press  input  1  left player (player2) press pulse, one cycle per press.
- r_press  input  1  right player (player1) press pulse, one cycle per press.
- field  output  FIELD_LEDS  one-hot playing field. Bit FIELD_LEDS-1 is the left end, bit 0 is the right end.
- score_l  output  $clog2(WIN_ROUNDS+1)  left round wins.
- score_r  output  $clog2(WIN_ROUNDS+1)  right round wins.
- round_done  output  1  one-cycle pulse when a round is won.
- round_winner  output  1  winner of the last round (1 = left, 0 = right). Holds its value until the next round_done.
- match_over  output  1  high once either score reaches WIN_ROUNDS.
- match_winner  output  1  1 = left, 0 = right. Valid while match_over is high.

Behaviour:
- Reset is asserted when reset is low, acting immediately and asynchronously, including mid-hold or mid-match. Reset values:
  - position = centre, so field has only the centre bit set;
  - score_l = score_r = 0;
  - round_done = round_winner = match_over = match_winner = 0;
  - state = PLAY; hold counter = 0.
- Internal position register pos has width $clog2(FIELD_LEDS). field = 1 << pos, registered, so exactly one bit is always set.
- State PLAY, evaluated at each clk rising edge:
  - l_press & r_press together: cancel, no change.
  - l_press only, pos < FIELD_LEDS-1: pos+1 (light moves left).
  - r_press only, pos > 0: pos-1 (light moves right).
  - l_press only, pos == FIELD_LEDS-1: left wins the round. score_l+1, round_winner=1, round_done pulses next cycle, go to HOLD. pos unchanged.
  - r_press only, pos == 0: right wins the round. score_r+1, round_winner=0, round_done pulses, go to HOLD.
  - Neither press: hold.
- State HOLD:
  - All presses are ignored. The hold counter counts 0..HOLD_CYCLES-1 and field keeps the winning end LED lit.
  - On terminal count, if the incremented score == WIN_ROUNDS: go to DONE, assert match_over, set match_winner = round_winner.
  - Otherwise: pos = centre, counter = 0, go to PLAY.
  - Latency from the winning press to the re-centred field is HOLD_CYCLES+1 cycles.
- State DONE: absorbing.
  - Presses are ignored, field holds the winning end LED, scores frozen, match_over stays high.
  - Only reset leaves DONE.
- Scores never exceed WIN_ROUNDS; DONE guarantees no further increments.
- round_done is a single-cycle pulse: it is high only in the cycle that follows the winning press edge.
- Presses arriving in the same cycle as the HOLD→PLAY transition are ignored. The first press is accepted in the cycle after re-centring.

Optional Feature:
- Macro TUG_EDGE_DETECT_EN.
- Defined: l_press and r_press may be raw level signals.
  - Each input has an internal previous-value flop, reset to 0.
  - Only a 0→1 transition counts as one press, so a held level produces exactly one move.
- Undefined: inputs are taken as already one-cycle pulses. Every high cycle counts as a press, and no edge flops are instantiated.

Test Plan (FIELD_LEDS=9, WIN_ROUNDS=2, HOLD_CYCLES=4):
1. Release reset, no presses for 5 cycles -> field=9'b000010000, scores 0, match_over=0.
2. Five l_press pulses, spaced 2 cycles apart:
   - field steps to 9'b100000000 after the 4th pulse;
   - the 5th pulse gives round_done for 1 cycle, round_winner=1, score_l=1;
   - 4 hold cycles later field=9'b000010000.
3. l_press and r_press high in the same cycle at centre -> field unchanged, no score change.
4. After scenario 2, five r_press pulses, then five more r_press pulses -> score_r=1, then score_r=2, match_over=1, match_winner=0, field=9'b000000001. Further presses leave all outputs unchanged.
5. Press l_press during HOLD -> ignored; field re-centres exactly 4 cycles after the round win.
6. Assert reset (low) mid-HOLD, between clock edges -> outputs return to reset values immediately.
   - With TUG_EDGE_DETECT_EN defined: additionally hold l_press high for 6 cycles -> pos moves exactly once (field=9'b000100000).
